// File: rtl/fp_pkg.sv
// Shared widths and the sign/exponent/mantissa operand bundle for the FP add/sub unit.
package fp_pkg;
  localparam int unsigned MANT_W = 11;
  localparam int unsigned EXP_W  = 5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;
endpackage

// File: rtl/fp_lzc_norm.sv
// Left-normalizes a mantissa by its leading-zero count, lowering the exponent to match;
// flags a zero result when the mantissa is zero or the shift would underflow the exponent.
module fp_lzc_norm
  import fp_pkg::*;
#(
  parameter int unsigned MANT_W = fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W:0]    i_exp,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W:0]    o_exp,
  output logic              o_zero
);

  logic [EXP_W:0] w_cnt;

  always_comb begin
    // Highest set bit wins, so the last match in the upward scan sets the count.
    w_cnt = (EXP_W+1)'(MANT_W);
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (i_mant[i]) w_cnt = (EXP_W+1)'(MANT_W - 1 - i);
    end
    o_zero = (i_mant == '0) || (w_cnt > i_exp);
    o_mant = i_mant << w_cnt;
    o_exp  = i_exp - w_cnt;
  end

endmodule

// File: rtl/floating_pt_oper.sv
// Floating-point add/subtract: compare, align, add or subtract magnitudes, normalize,
// and register the result (one-cycle latency, one operand set per cycle).
module floating_pt_oper
  import fp_pkg::*;
#(
  parameter int unsigned MANT_W = fp_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MANT_W-1:0] inp1,
  input  logic              sgn1,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [MANT_W-1:0] inp2,
  input  logic              sgn2,
  input  logic [EXP_W-1:0]  exp2,
  input  logic              operatin,
  output logic [MANT_W-1:0] out,
  output logic              sgnout,
  output logic [EXP_W:0]    outexp
);

  localparam logic [EXP_W:0] SH_LIM  = (EXP_W+1)'(MANT_W);
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  fp_t               w_a, w_b, w_big, w_small;
  logic              w_s2e, w_sub, w_op1_big;
  logic [EXP_W-1:0]  w_shamt;
  logic [MANT_W-1:0] w_aligned, w_diff, w_pre_mant;
  logic [MANT_W:0]   w_sum;
  logic [EXP_W:0]    w_pre_exp;
  logic [MANT_W-1:0] w_n_mant;
  logic [EXP_W:0]    w_n_exp;
  logic              w_n_zero;

  always_comb begin
    w_s2e     = sgn2 ^ operatin;
    w_sub     = sgn1 ^ w_s2e;
    w_a       = {sgn1, exp1, inp1};
    w_b       = {w_s2e, exp2, inp2};
    w_op1_big = (exp1 > exp2) || ((exp1 == exp2) && (inp1 >= inp2));
    w_big     = w_op1_big ? w_a : w_b;
    w_small   = w_op1_big ? w_b : w_a;

    w_shamt   = w_big.exp - w_small.exp;
    w_aligned = ({1'b0, w_shamt} >= SH_LIM) ? '0 : (w_small.mant >> w_shamt);

    w_sum      = {1'b0, w_big.mant} + {1'b0, w_aligned};
    w_diff     = w_big.mant - w_aligned;
    w_pre_exp  = {1'b0, w_big.exp};
    w_pre_mant = w_diff;
    if (!w_sub) begin
      if (w_sum[MANT_W]) begin
        w_pre_mant = w_sum[MANT_W:1];
        w_pre_exp  = {1'b0, w_big.exp} + EXP_ONE;
      end else begin
        w_pre_mant = w_sum[MANT_W-1:0];
      end
    end
  end

  fp_lzc_norm #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_norm (
    .i_mant (w_pre_mant),
    .i_exp  (w_pre_exp),
    .o_mant (w_n_mant),
    .o_exp  (w_n_exp),
    .o_zero (w_n_zero)
  );

  always_ff @(posedge clk) begin
    if (rst || w_n_zero) begin
      out    <= '0;
      sgnout <= 1'b0;
      outexp <= '0;
    end else begin
      out    <= w_n_mant;
      sgnout <= w_big.sign;
      outexp <= w_n_exp;
    end
  end

endmodule

// File: tb/tb_floating_pt_oper.sv
// Directed bench for floating_pt_oper with a queue of expected results checked one cycle after drive.
module tb_floating_pt_oper;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] inp1, inp2;
  logic        sgn1, sgn2;
  logic [4:0]  exp1, exp2;
  logic        operatin;
  logic [10:0] out;
  logic        sgnout;
  logic [5:0]  outexp;

  typedef struct {
    string       tag;
    logic        s;
    logic [5:0]  e;
    logic [10:0] m;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  floating_pt_oper #(
    .MANT_W (11),
    .EXP_W  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inp1     (inp1),
    .sgn1     (sgn1),
    .exp1     (exp1),
    .inp2     (inp2),
    .sgn2     (sgn2),
    .exp2     (exp2),
    .operatin (operatin),
    .out      (out),
    .sgnout   (sgnout),
    .outexp   (outexp)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r,
                      input logic s1, input int e1, input int m1,
                      input logic s2, input int e2, input int m2,
                      input logic op,
                      input logic xs, input int xe, input int xm);
    exp_t x, got;
    rst = r; sgn1 = s1; exp1 = 5'(e1); inp1 = 11'(m1);
    sgn2 = s2; exp2 = 5'(e2); inp2 = 11'(m2); operatin = op;
    x.tag = tag; x.s = xs; x.e = 6'(xe); x.m = 11'(xm);
    q.push_back(x);
    @(posedge clk);
    #1;
    got = q.pop_front();
    total++;
    assert ({sgnout, outexp, out} === {got.s, got.e, got.m}) else begin
      bad++;
      $error("FAIL %s: got s=%0b e=%0d m=%0d, expected s=%0b e=%0d m=%0d",
             got.tag, sgnout, outexp, out, got.s, got.e, got.m);
    end
  endtask

  initial begin
    //   tag          rst s1 e1  m1    s2 e2  m2    op  xs xe  xm
    step("reset1",    1,  0, 17, 1536, 0, 11, 1540, 0,  0, 0,  0);
    step("reset2",    1,  1, 31, 2047, 0, 31, 2047, 0,  0, 0,  0);
    step("add_nc1",   0,  0, 17, 1536, 0, 11, 1540, 0,  0, 17, 1560);
    step("add_nc2",   0,  0, 14, 1539, 0, 11, 1537, 0,  0, 14, 1731);
    step("carry1",    0,  0, 11, 1026, 0, 11, 1028, 0,  0, 12, 1027);
    step("carry2",    0,  0, 9,  1484, 0, 11, 1691, 0,  0, 12, 1031);
    step("sub_norm",  0,  0, 11, 1026, 0, 11, 1028, 1,  1, 2,  1024);
    step("cancel",    0,  0, 11, 1026, 0, 11, 1026, 1,  0, 0,  0);
    step("mixed",     0,  1, 17, 1280, 0, 16, 1536, 0,  1, 16, 1024);
    step("overflow",  0,  0, 31, 2047, 0, 31, 2047, 0,  0, 32, 2047);
    step("shift11",   0,  0, 20, 1024, 0, 9,  2047, 0,  0, 20, 1024);
    step("shift10",   0,  0, 19, 1024, 0, 9,  2047, 0,  0, 19, 1025);
    step("flush",     0,  0, 3,  1028, 0, 3,  1026, 1,  0, 0,  0);
    step("cnt_eq_e",  0,  0, 9,  1028, 0, 9,  1026, 1,  0, 0,  1024);
    step("unnorm",    0,  0, 10, 256,  0, 0,  0,    0,  0, 8,  1024);
    step("unn_flush", 0,  0, 5,  3,    0, 0,  0,    0,  0, 0,  0);
    step("neg_sub",   0,  0, 12, 1024, 1, 12, 1024, 1,  0, 13, 1024);
    step("both_neg",  0,  1, 5,  1100, 1, 5,  1000, 0,  1, 6,  1050);
    step("sub_op2",   0,  0, 10, 1500, 0, 12, 1200, 1,  1, 11, 1650);
    step("mix_tie",   0,  1, 7,  1500, 0, 7,  1500, 0,  0, 0,  0);
    step("reset_mid", 1,  0, 31, 2047, 0, 31, 2047, 0,  0, 0,  0);
    step("post_rst",  0,  0, 11, 1026, 0, 11, 1028, 0,  0, 12, 1027);

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_empty: got %0d entries, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
